// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared types and helpers for the line-fill/writeback arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        AR   = 3'd1,
        R    = 3'd2,
        AW   = 3'd3,
        W    = 3'd4,
        B    = 3'd5,
        DONE = 3'd6
    } arb_state_t;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    // Ceiling log2; used for beat-counter width, AXI size and line offset.
    function automatic int log2Ceil(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) result = i + 1;
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Two-way round-robin picker; favours the requester not granted
//               most recently when both are asking.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       en,
    output logic       gnt_idx,
    output logic       gnt_valid
);

    logic r_last;

    always_comb begin
        gnt_valid = |req;
        if (req == 2'b11) gnt_idx = ~r_last;
        else              gnt_idx = req[1];
    end

    // Reset to 1 so requester 0 wins the first contention.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                  r_last <= 1'b1;
        else if (en && gnt_valid)   r_last <= gnt_idx;
    end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Serialises cache-line fills/writebacks from two requesters
//               onto one AXI4 master port as fixed-length INCR bursts.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 64,
    parameter int LINE_BEATS = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [1:0]                   req,
    input  logic [1:0]                   we,
    input  logic [ADDR_W-1:0]            addr0,
    input  logic [ADDR_W-1:0]            addr1,
    input  logic [DATA_W*LINE_BEATS-1:0] wline0,
    input  logic [DATA_W*LINE_BEATS-1:0] wline1,
    output logic [1:0]                   done,
    output logic [DATA_W*LINE_BEATS-1:0] rline,
    output logic                         stall_miss1,
    output logic                         stall_miss2,
    output logic                         arvalid,
    input  logic                         arready,
    output logic [ADDR_W-1:0]            araddr,
    output logic [7:0]                   arlen,
    output logic [2:0]                   arsize,
    output logic [1:0]                   arburst,
    input  logic                         rvalid,
    output logic                         rready,
    input  logic [DATA_W-1:0]            rdata,
    input  logic                         rlast,
    output logic                         awvalid,
    input  logic                         awready,
    output logic [ADDR_W-1:0]            awaddr,
    output logic [7:0]                   awlen,
    output logic [2:0]                   awsize,
    output logic [1:0]                   awburst,
    output logic                         wvalid,
    input  logic                         wready,
    output logic [DATA_W-1:0]            wdata,
    output logic                         wlast,
    input  logic                         bvalid,
    output logic                         bready
);

    localparam int                  c_BEAT_W     = log2Ceil(LINE_BEATS);
    localparam int                  c_OFFSET_W   = log2Ceil(LINE_BEATS * DATA_W / 8);
    localparam int                  c_LINE_W     = DATA_W * LINE_BEATS;
    localparam logic [c_BEAT_W-1:0] c_LAST_BEAT  = c_BEAT_W'(LINE_BEATS - 1);
    localparam logic [ADDR_W-1:0]   c_ALIGN_MASK = {ADDR_W{1'b1}} << c_OFFSET_W;
    localparam logic [7:0]          c_AXI_LEN    = 8'(LINE_BEATS - 1);
    localparam logic [2:0]          c_AXI_SIZE   = 3'(log2Ceil(DATA_W / 8));

    arb_state_t            r_state;
    arb_state_t            w_nextState;
    logic [c_BEAT_W-1:0]   r_beat;
    logic                  r_gntIdx;
    logic [ADDR_W-1:0]     r_addr;
    logic [c_LINE_W-1:0]   r_wline;
    logic [c_LINE_W-1:0]   r_rline;

    logic w_gntIdx;
    logic w_gntValid;
    logic w_grant;
    logic w_lastBeat;
    logic w_rBeatFire;
    logic w_wBeatFire;
    logic w_unused;

    // Burst length is fixed, so rlast carries no extra information.
    assign w_unused = rlast;

    rr_arb2 u_rrArb (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .en        (r_state == IDLE),
        .gnt_idx   (w_gntIdx),
        .gnt_valid (w_gntValid)
    );

    assign w_grant     = (r_state == IDLE) && w_gntValid;
    assign w_lastBeat  = (r_beat == c_LAST_BEAT);
    assign w_rBeatFire = (r_state == R) && rvalid;
    assign w_wBeatFire = (r_state == W) && wready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: if (w_gntValid) w_nextState = we[w_gntIdx] ? AW : AR;
            AR:   if (arready) w_nextState = R;
            R:    if (rvalid && w_lastBeat) w_nextState = DONE;
            AW:   if (awready) w_nextState = W;
            W:    if (wready && w_lastBeat) w_nextState = B;
            B:    if (bvalid) w_nextState = DONE;
            DONE: w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_comb begin
        arvalid = 1'b0;
        rready  = 1'b0;
        awvalid = 1'b0;
        wvalid  = 1'b0;
        bready  = 1'b0;
        done    = 2'b00;
        case (r_state)
            AR:   arvalid = 1'b1;
            R:    rready  = 1'b1;
            AW:   awvalid = 1'b1;
            W:    wvalid  = 1'b1;
            B:    bready  = 1'b1;
            DONE: done[r_gntIdx] = 1'b1;
            default: ;
        endcase
    end

    // Request inputs are captured once at grant; the beat counter wraps to
    // zero on the final beat because LINE_BEATS is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_beat   <= '0;
            r_gntIdx <= 1'b0;
            r_addr   <= '0;
            r_wline  <= '0;
            r_rline  <= '0;
        end else begin
            if (w_grant) begin
                r_gntIdx <= w_gntIdx;
                r_addr   <= (w_gntIdx ? addr1 : addr0) & c_ALIGN_MASK;
                r_wline  <= w_gntIdx ? wline1 : wline0;
                r_beat   <= '0;
            end
            if (w_rBeatFire) begin
                r_rline[int'(r_beat) * DATA_W +: DATA_W] <= rdata;
                r_beat <= r_beat + 1'b1;
            end
            if (w_wBeatFire) r_beat <= r_beat + 1'b1;
        end
    end

    assign araddr  = r_addr;
    assign arlen   = c_AXI_LEN;
    assign arsize  = c_AXI_SIZE;
    assign arburst = AXI_BURST_INCR;
    assign awaddr  = r_addr;
    assign awlen   = c_AXI_LEN;
    assign awsize  = c_AXI_SIZE;
    assign awburst = AXI_BURST_INCR;
    assign wdata   = r_wline[int'(r_beat) * DATA_W +: DATA_W];
    assign wlast   = (r_state == W) && w_lastBeat;
    assign rline   = r_rline;

    assign stall_miss1 = req[0] & ~done[0];
    assign stall_miss2 = req[1] & ~done[1];

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Directed self-checking bench for mem_arbiter with a simple
//               in-line AXI slave and requester model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int ADDR_W     = 64;
    localparam int DATA_W     = 64;
    localparam int LINE_BEATS = 8;
    localparam int c_LINE_W   = DATA_W * LINE_BEATS;

    logic                clk;
    logic                reset;
    logic [1:0]          req;
    logic [1:0]          we;
    logic [ADDR_W-1:0]   addr0, addr1;
    logic [c_LINE_W-1:0] wline0, wline1;
    logic [1:0]          done;
    logic [c_LINE_W-1:0] rline;
    logic                stall_miss1, stall_miss2;
    logic                arvalid, arready;
    logic [ADDR_W-1:0]   araddr;
    logic [7:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;
    logic                rvalid, rready, rlast;
    logic [DATA_W-1:0]   rdata;
    logic                awvalid, awready;
    logic [ADDR_W-1:0]   awaddr;
    logic [7:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic                wvalid, wready, wlast;
    logic [DATA_W-1:0]   wdata;
    logic                bvalid, bready;

    mem_arbiter #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .LINE_BEATS (LINE_BEATS)
    ) dut (
        .clk (clk), .reset (reset), .req (req), .we (we),
        .addr0 (addr0), .addr1 (addr1), .wline0 (wline0), .wline1 (wline1),
        .done (done), .rline (rline),
        .stall_miss1 (stall_miss1), .stall_miss2 (stall_miss2),
        .arvalid (arvalid), .arready (arready), .araddr (araddr),
        .arlen (arlen), .arsize (arsize), .arburst (arburst),
        .rvalid (rvalid), .rready (rready), .rdata (rdata), .rlast (rlast),
        .awvalid (awvalid), .awready (awready), .awaddr (awaddr),
        .awlen (awlen), .awsize (awsize), .awburst (awburst),
        .wvalid (wvalid), .wready (wready), .wdata (wdata), .wlast (wlast),
        .bvalid (bvalid), .bready (bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          nAssert = 0;
    int          nFail   = 0;
    int          cyc;
    bit          bp;
    int          addrStall;
    int          rbeatSent;
    logic [63:0] rdataBase;
    logic [63:0] wcap[$];
    bit          wlastCap[$];
    int          grants[$];
    int          doneCnt;
    int          stableErr;
    int          smErr;
    bit          pendAr, pendAw, pendW;
    logic [63:0] holdAr, holdAw, holdW;
    logic [63:0] arSeen, awSeen;
    logic [1:0]  reissue;
    int          t1, t2;

    task automatic chk(input string tag, input logic [c_LINE_W-1:0] obs,
                       input logic [c_LINE_W-1:0] exp);
        nAssert++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [c_LINE_W-1:0] mkLine(input logic [63:0] base);
        logic [c_LINE_W-1:0] l;
        for (int i = 0; i < LINE_BEATS; i++) l[i*DATA_W +: DATA_W] = base + 64'(i);
        return l;
    endfunction

    // AXI slave: decisions are made at the falling edge from the DUT's
    // registered outputs and take effect at the next rising edge.
    task automatic slaveCycle();
        bit go;
        go = !bp || ((cyc % 2) == 1);
        if (reset) begin
            arready = 0; awready = 0; rvalid = 0; wready = 0; bvalid = 0; rlast = 0;
            pendAr = 0; pendAw = 0; pendW = 0;
            return;
        end
        if (pendAr && (!arvalid || araddr !== holdAr)) stableErr++;
        if (pendAw && (!awvalid || awaddr !== holdAw)) stableErr++;
        if (pendW  && (!wvalid  || wdata  !== holdW))  stableErr++;
        arready = 0;
        awready = 0;
        if (arvalid) begin
            if (addrStall > 0) addrStall--; else begin arready = 1; arSeen = araddr; end
        end
        if (awvalid) begin
            if (addrStall > 0) addrStall--; else begin awready = 1; awSeen = awaddr; end
        end
        pendAr = arvalid && !arready; holdAr = araddr;
        pendAw = awvalid && !awready; holdAw = awaddr;
        rvalid = 0; rlast = 0; rdata = '0;
        if (rready && go) begin
            rvalid = 1;
            rlast  = ((rbeatSent % LINE_BEATS) == LINE_BEATS - 1);
            rdata  = rdataBase + 64'(rbeatSent);
            rbeatSent++;
        end
        wready = 0;
        if (wvalid && go) begin
            wready = 1;
            wcap.push_back(wdata);
            wlastCap.push_back(wlast);
        end
        pendW = wvalid && !wready; holdW = wdata;
        bvalid = bready;
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        if ({stall_miss2, stall_miss1} !== (req & ~done)) smErr++;
        if (done[0]) begin doneCnt++; grants.push_back(0); end
        if (done[1]) begin doneCnt++; grants.push_back(1); end
        slaveCycle();
        for (int k = 0; k < 2; k++) begin
            if (done[k])                     req[k] = 1'b0;
            else if (reissue[k] && !req[k])  req[k] = 1'b1;
        end
    endtask

    task automatic runUntilDone(input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            step();
            if (done != 2'b00) begin at = cyc; break; end
        end
        chk("doneWithinBudget", 512'(at >= 0), 512'(1));
    endtask

    task automatic doReset();
        reset = 1; req = 0; reissue = 0; bp = 0; addrStall = 0;
        step();
        step();
    endtask

    initial begin
        reset = 1; req = 0; we = 0; addr0 = 0; addr1 = 0; wline0 = 0; wline1 = 0;
        arready = 0; awready = 0; rvalid = 0; rdata = 0; rlast = 0; wready = 0; bvalid = 0;
        bp = 0; addrStall = 0; rbeatSent = 0; rdataBase = 0; doneCnt = 0;
        stableErr = 0; smErr = 0; reissue = 0; cyc = 0;
        pendAr = 0; pendAw = 0; pendW = 0; holdAr = 0; holdAw = 0; holdW = 0;
        arSeen = 0; awSeen = 0;

        // ---- reset values
        doReset();
        chk("rst_done",    512'(done),    512'(0));
        chk("rst_arvalid", 512'(arvalid), 512'(0));
        chk("rst_awvalid", 512'(awvalid), 512'(0));
        chk("rst_wvalid",  512'(wvalid),  512'(0));
        chk("rst_rready",  512'(rready),  512'(0));
        chk("rst_bready",  512'(bready),  512'(0));
        chk("rst_araddr",  512'(araddr),  512'(0));
        chk("rst_awaddr",  512'(awaddr),  512'(0));
        chk("rst_rline",   rline,         512'(0));
        reset = 0;

        // ---- single fill, requester 0
        cyc = 0; rbeatSent = 0; rdataBase = 64'h0;
        addr0 = 64'h1038; we = 2'b00; req = 2'b01;
        step();
        chk("A_arvalid", 512'(arvalid), 512'(1));
        chk("A_araddr",  512'(araddr),  512'(64'h1000));
        chk("A_arlen",   512'(arlen),   512'(7));
        chk("A_arsize",  512'(arsize),  512'(3));
        chk("A_arburst", 512'(arburst), 512'(1));
        chk("A_stall1",  512'(stall_miss1), 512'(1));
        runUntilDone(40, t1);
        chk("A_doneCycle", 512'(t1 + 1), 512'(11));
        chk("A_done",      512'(done),   512'(2'b01));
        chk("A_rline",     rline,        mkLine(64'h0));
        chk("A_stall1AtDone", 512'(stall_miss1), 512'(0));
        step();
        chk("A_donePulse", 512'(done), 512'(0));

        // ---- writeback, requester 1; wline1 changes after grant are ignored
        cyc = 0; wcap.delete(); wlastCap.delete();
        addr1 = 64'h20F08; we = 2'b10;
        for (int i = 0; i < LINE_BEATS; i++) wline1[i*DATA_W +: DATA_W] = 64'hA0 + 64'(i);
        req = 2'b10;
        step();
        wline1 = '0;
        chk("B_awvalid", 512'(awvalid), 512'(1));
        chk("B_awaddr",  512'(awaddr),  512'(64'h20F00));
        chk("B_awlen",   512'(awlen),   512'(7));
        runUntilDone(40, t1);
        chk("B_doneCycle", 512'(t1 + 1), 512'(12));
        chk("B_done",      512'(done),   512'(2'b10));
        chk("B_wbeats",    512'(wcap.size()), 512'(8));
        for (int i = 0; i < LINE_BEATS; i++) begin
            chk($sformatf("B_wdata%0d", i),
                512'((i < wcap.size()) ? wcap[i] : 64'hDEAD), 512'(64'hA0 + 64'(i)));
            chk($sformatf("B_wlast%0d", i),
                512'((i < wlastCap.size()) ? wlastCap[i] : 1'b0), 512'(i == LINE_BEATS - 1));
        end

        // ---- contention straight after reset: requester 0 first
        doReset();
        reset = 0;
        cyc = 0; smErr = 0; rbeatSent = 0; rdataBase = 64'h100;
        we = 2'b00; addr0 = 64'h3000; addr1 = 64'h4078; req = 2'b11;
        runUntilDone(40, t1);
        chk("C_first",       512'(done),        512'(2'b01));
        chk("C_firstAddr",   512'(arSeen),      512'(64'h3000));
        chk("C_firstLine",   rline,             mkLine(64'h100));
        chk("C_stall2",      512'(stall_miss2), 512'(1));
        runUntilDone(40, t2);
        chk("C_second",      512'(done),        512'(2'b10));
        chk("C_backToBack",  512'(t2 - t1),     512'(11));
        chk("C_secondAddr",  512'(arSeen),      512'(64'h4040));
        chk("C_secondLine",  rline,             mkLine(64'h108));

        // ---- fairness with continuous reissue
        grants.delete();
        reissue = 2'b11; req = 2'b11;
        for (int n = 0; n < 5; n++) begin
            runUntilDone(60, t1);
            if (n == 3) reissue = 2'b00;
        end
        for (int i = 0; i < 5; i++)
            chk($sformatf("D_grant%0d", i),
                512'((i < grants.size()) ? grants[i] : -1), 512'(i % 2));
        chk("D_stallMiss", 512'(smErr), 512'(0));

        // ---- backpressure: fill then writeback
        cyc = 0; bp = 1; addrStall = 3; stableErr = 0; doneCnt = 0;
        rbeatSent = 0; rdataBase = 64'h200;
        we = 2'b00; addr1 = 64'h8123; req = 2'b10;
        runUntilDone(80, t1);
        chk("E_fillDone",  512'(done),      512'(2'b10));
        chk("E_fillAddr",  512'(arSeen),    512'(64'h8100));
        chk("E_fillBeats", 512'(rbeatSent), 512'(8));
        chk("E_fillLine",  rline,           mkLine(64'h200));
        for (int i = 0; i < 5; i++) step();
        chk("E_oneDone",   512'(doneCnt),   512'(1));

        cyc = 0; addrStall = 3; wcap.delete(); wlastCap.delete();
        we = 2'b01; addr0 = 64'h503F;
        for (int i = 0; i < LINE_BEATS; i++) wline0[i*DATA_W +: DATA_W] = 64'hC0 + 64'(i);
        req = 2'b01;
        runUntilDone(80, t1);
        chk("E_wbDone",   512'(done),        512'(2'b01));
        chk("E_wbAddr",   512'(awSeen),      512'(64'h5000));
        chk("E_wbBeats",  512'(wcap.size()), 512'(8));
        for (int i = 0; i < LINE_BEATS; i++)
            chk($sformatf("E_wdata%0d", i),
                512'((i < wcap.size()) ? wcap[i] : 64'hDEAD), 512'(64'hC0 + 64'(i)));
        chk("E_lastFlag", 512'((wlastCap.size() == 8) ? wlastCap[7] : 1'b0), 512'(1));
        chk("E_stable",   512'(stableErr),   512'(0));
        bp = 0;

        // ---- reset in the middle of an R burst
        step();
        cyc = 0; rbeatSent = 0; rdataBase = 64'h300;
        we = 2'b00; addr0 = 64'h6010; req = 2'b01;
        for (int i = 0; i < 20 && rbeatSent < 4; i++) step();
        chk("F_beatsOffered", 512'(rbeatSent), 512'(4));
        @(negedge clk);
        chk("F_inR",     512'(rready), 512'(1));
        chk("F_partial", 512'(rline[3*DATA_W +: DATA_W]), 512'(64'h303));
        rvalid = 0; req = 2'b00; reset = 1;
        #1;
        chk("F_rstRready",  512'(rready),  512'(0));
        chk("F_rstArvalid", 512'(arvalid), 512'(0));
        chk("F_rstDone",    512'(done),    512'(0));
        chk("F_rstAraddr",  512'(araddr),  512'(0));
        chk("F_rstRline",   rline,         512'(0));
        step();
        reset = 0;
        cyc = 0; rbeatSent = 0; rdataBase = 64'h400; addr0 = 64'h7000; req = 2'b01;
        runUntilDone(40, t1);
        chk("F_freshCycle", 512'(t1 + 1), 512'(11));
        chk("F_freshDone",  512'(done),   512'(2'b01));
        chk("F_freshLine",  rline,        mkLine(64'h400));
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule
`default_nettype wire
